// File: rtl/uart8_rx_flow_decoder_if.sv
// FIFO write port of the UART receiver: a byte plus a one-cycle write strobe,
// with the downstream full flag sampled when a finished byte is classified.
interface uart8_rx_flow_decoder_if;
  // Handshake: wr_en is a single-cycle strobe that always carries valid
  // data_out. There is no stall path. fifo_full is sampled only in the cycle
  // a frame completes, and a full FIFO turns that byte into an overrun.
  logic [7:0] data_out;
  logic       wr_en;
  logic       fifo_full;

  modport master (
    output data_out,
    output wr_en,
    input  fifo_full
  );

  modport slave (
    input  data_out,
    input  wr_en,
    output fifo_full
  );
endinterface

// File: rtl/uart8_rx_flow_decoder.sv
// 8N1 UART receiver with oversampled start/data/stop sampling, XON/XOFF
// flow-control decoding, overrun tracking and break detection.
module uart8_rx_flow_decoder #(
  parameter int         OVERSAMPLE  = 16,
  parameter logic [7:0] XON_CHAR    = 8'h11,
  parameter logic [7:0] XOFF_CHAR   = 8'h13,
  parameter bit         FILTER_CTRL = 1'b1
) (
  input  logic                           rxClk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           rxd,
  input  logic                           overrun_clr,
  uart8_rx_flow_decoder_if.master        fifo,
  output logic                           busy,
  output logic                           frame_err,
  output logic                           overrun,
  output logic                           tx_pause,
  output logic [2:0]                     dbg_state_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic [7:0]    shreg_d;
  logic          rx_meta_q;
  logic          rxs_q;
  logic [7:0]    data_out_q;
  logic          wr_en_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          tx_pause_q;

  logic          is_xoff;
  logic          is_xon;

  assign cnt_d   = cnt_q + 1'b1;
  assign shreg_d = {rxs_q, shreg_q[7:1]};

  // Control characters are only special when filtering is enabled.
  assign is_xoff = FILTER_CTRL && (shreg_q == XOFF_CHAR);
  assign is_xon  = FILTER_CTRL && (shreg_q == XON_CHAR);

  always_ff @(posedge rxClk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      data_out_q  <= 8'h00;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      tx_pause_q  <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rxs_q       <= rx_meta_q;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      // A new overrun later in this block overrides the clear.
      if (overrun_clr) overrun_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (en && !rxs_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end

        S_START: begin
          if (cnt_q == HALF_TICK) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxs_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_DATA: begin
          if (cnt_q == LAST_TICK) begin
            cnt_q   <= '0;
            shreg_q <= shreg_d;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_STOP: begin
          if (cnt_q == LAST_TICK) begin
            cnt_q <= '0;
            if (rxs_q) begin
              // Classification lands in the cycle after the stop sample.
              state_q <= S_IDLE;
              if (is_xoff) begin
                tx_pause_q <= 1'b1;
              end else if (is_xon) begin
                tx_pause_q <= 1'b0;
              end else if (fifo.fifo_full) begin
                overrun_q <= 1'b1;
              end else begin
                data_out_q <= shreg_q;
                wr_en_q    <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_BREAK: begin
          if (rxs_q) state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign fifo.data_out = data_out_q;
  assign fifo.wr_en    = wr_en_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign tx_pause      = tx_pause_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart8_rx_flow_decoder.sv
// Directed bench for uart8_rx_flow_decoder at 16 ticks per bit with an
// expected-write queue checked by a free-running monitor.
module tb_uart8_rx_flow_decoder;

  logic       rxClk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rxd = 1'b1;
  logic       overrun_clr = 1'b0;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       tx_pause;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         n_checks = 0;
  int         n_errors = 0;
  int         fe_seen = 0;
  bit         ov_seen = 1'b0;

  uart8_rx_flow_decoder_if fifo_if ();

  // clock / reset
  always #5 rxClk = ~rxClk;

  uart8_rx_flow_decoder #(
    .OVERSAMPLE (16),
    .XON_CHAR   (8'h11),
    .XOFF_CHAR  (8'h13),
    .FILTER_CTRL(1'b1)
  ) dut (
    .rxClk      (rxClk),
    .rst_n      (rst_n),
    .en         (en),
    .rxd        (rxd),
    .overrun_clr(overrun_clr),
    .fifo       (fifo_if),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .tx_pause   (tx_pause),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge rxClk) begin
    if (rst_n) begin
      if (fifo_if.wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got data_out=%0h expected no write", fifo_if.data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("write_data", 32'(fifo_if.data_out), 32'(mon_exp));
        end
      end
      if (frame_err === 1'b1) fe_seen++;
      if (overrun === 1'b1) ov_seen = 1'b1;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge rxClk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    rxd = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit drop_en);
    drive(1'b0, 16);
    if (drop_en) en = 1'b0;
    for (int i = 0; i < 8; i++) drive(b[i], 16);
    drive(stop_bit, 16);
    en = 1'b1;
  endtask

  initial begin
    fifo_if.fifo_full = 1'b0;
    @(posedge rxClk);
    #1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    check("rst_data_out", 32'(fifo_if.data_out), 32'h00);
    check("rst_wr_en", 32'(fifo_if.wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_tx_pause", 32'(tx_pause), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    en = 1'b1;
    tick(4);

    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("a5_written", 32'(exp_q.size()), 32'd0);
    check("a5_busy_low", 32'(busy), 32'd0);
    check("a5_data_hold", 32'(fifo_if.data_out), 32'hA5);

    send_frame(8'h13, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("xoff_pause", 32'(tx_pause), 32'd1);
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("x41_written", 32'(exp_q.size()), 32'd0);
    check("x41_pause_kept", 32'(tx_pause), 32'd1);
    send_frame(8'h13, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("xoff_repeat", 32'(tx_pause), 32'd1);
    send_frame(8'h11, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("xon_resume", 32'(tx_pause), 32'd0);
    check("ctrl_no_write", 32'(fifo_if.data_out), 32'h41);

    drive(1'b0, 4);
    drive(1'b1, 12);
    check("false_start_busy", 32'(busy), 32'd0);
    check("false_start_idle", 32'(dbg_state), 32'd0);
    check("false_start_no_fe", 32'(fe_seen), 32'd0);

    send_frame(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 40);
    check("break_state", 32'(dbg_state), 32'd4);
    check("break_busy", 32'(busy), 32'd1);
    check("break_fe_once", 32'(fe_seen), 32'd1);
    drive(1'b1, 4);
    check("break_exit", 32'(dbg_state), 32'd0);
    drive(1'b1, 8);

    fifo_if.fifo_full = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("overrun_set", 32'(overrun), 32'd1);
    fifo_if.fifo_full = 1'b0;
    tick(16);
    check("overrun_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    tick(1);
    check("overrun_cleared", 32'(overrun), 32'd0);

    ov_seen = 1'b0;
    fifo_if.fifo_full = 1'b1;
    overrun_clr = 1'b1;
    send_frame(8'h77, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("overrun_set_wins", 32'(ov_seen), 32'd1);
    check("overrun_clr_after", 32'(overrun), 32'd0);
    overrun_clr = 1'b0;
    fifo_if.fifo_full = 1'b0;

    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(1'b1, 16);
    drive(1'b1, 8);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("midrst_idle", 32'(dbg_state), 32'd0);
    check("midrst_data_out", 32'(fifo_if.data_out), 32'h00);
    drive(1'b1, 16);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("midrst_0f_written", 32'(exp_q.size()), 32'd0);

    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    send_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("b2b_written", 32'(exp_q.size()), 32'd0);

    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 1'b1);
    drive(1'b1, 8);
    check("en_drop_written", 32'(exp_q.size()), 32'd0);

    en = 1'b0;
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) drive(1'b1, 16);
    drive(1'b1, 16);
    en = 1'b1;
    check("en_off_idle", 32'(dbg_state), 32'd0);

    drive(1'b1, 16);
    check("final_fe_count", 32'(fe_seen), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart8_rx_flow_decoder.md
UART8_RX_FLOW_DECODER -- requirements
Module: uart8_rx_flow_decoder

Interface
REQ-001 Parameter OVERSAMPLE, default 16, SHALL set the number of rxClk ticks per bit period; legal values are even and at least 4.
REQ-002 Parameter XON_CHAR, default 8'h11, SHALL be the resume character.
REQ-003 Parameter XOFF_CHAR, default 8'h13, SHALL be the pause character.
REQ-004 Parameter FILTER_CTRL, default 1: when 1, XON/XOFF bytes are consumed and never written; when 0, all bytes are written and tx_pause stays 0.
REQ-005 rxClk  input  1  oversampling clock; every tick is one sample.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 en  input  1  enables detection of a new start bit.
REQ-008 rxd  input  1  asynchronous serial line; idles high.
REQ-009 fifo_full  input  1  downstream FIFO full.
REQ-010 overrun_clr  input  1  single-cycle clear of overrun.
REQ-011 data_out  output  8  received byte.
REQ-012 wr_en  output  1  one-cycle FIFO write strobe.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-015 overrun  output  1  sticky flag: a byte was dropped because fifo_full was high.
REQ-016 tx_pause  output  1  level: 1 after XOFF, 0 after XON.

Function
REQ-017 rxd SHALL pass through a 2-flop synchronizer (both flops reset to 1); all sampling SHALL use the synchronized value rxs.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, plus a tick counter and a 3-bit bit index.
REQ-019 IDLE: when en=1 and rxs=0, the FSM SHALL go to START and clear the tick counter.
REQ-020 START: at tick OVERSAMPLE/2-1, rxs=1 SHALL be treated as a false start (return to IDLE, no outputs); rxs=0 SHALL move to DATA with the counter cleared.
REQ-021 DATA: at each tick OVERSAMPLE-1, rxs SHALL be shifted in LSB first; after bit 7 the FSM SHALL move to STOP.
REQ-022 STOP: at tick OVERSAMPLE-1, rxs=1 SHALL complete the frame and return to IDLE.
REQ-023 STOP: at tick OVERSAMPLE-1, rxs=0 SHALL pulse frame_err for one cycle, discard the byte, and move to BREAK.
REQ-024 BREAK SHALL return to IDLE only on the first cycle with rxs=1.
REQ-025 Completion of a valid frame SHALL be classified in the following cycle, in priority order:
  - FILTER_CTRL=1 and byte==XOFF_CHAR: tx_pause<=1, no write.
  - FILTER_CTRL=1 and byte==XON_CHAR: tx_pause<=0, no write.
  - fifo_full=1: overrun<=1, no write.
  - otherwise: data_out<=byte and wr_en=1 for exactly one cycle.
REQ-026 wr_en SHALL assert 1 rxClk after the stop-bit sample; data_out SHALL hold its value until the next write.
REQ-027 A repeated XOFF or XON SHALL leave tx_pause unchanged; only the last control byte received matters.
REQ-028 Deasserting en mid-frame SHALL NOT abort the frame; en gates start detection only.
REQ-029 If overrun_clr and a new overrun occur in the same cycle, set SHALL win.
REQ-030 The FSM SHALL accept a start edge in the cycle immediately after returning to IDLE (back-to-back frames with a single stop bit).

Reset
REQ-031 With rst_n=0 at a rxClk edge, the FSM SHALL go to IDLE and counters SHALL clear.
REQ-032 Reset SHALL set data_out=8'h00, wr_en=0, busy=0, frame_err=0, overrun=0 and tx_pause=0, and SHALL set both synchronizer flops to 1.
REQ-033 Reset asserted mid-frame SHALL discard the partial byte; no wr_en or frame_err SHALL follow.

Verification (OVERSAMPLE=16)
REQ-034 Send frame 0xA5 at 16 ticks per bit -> exactly one wr_en pulse with data_out=0xA5; busy falls afterward.
REQ-035 Send 0x13 then 0x41 -> tx_pause=1 and no write for 0x13; then one write of 0x41. Send 0x11 -> tx_pause=0 and no write.
REQ-036 Drive rxd low for 4 ticks, then high -> no wr_en, no frame_err, busy returns to 0 by tick 8.
REQ-037 Send frame 0x3C with the stop bit low, holding rxd low for 40 more ticks -> one frame_err pulse, no wr_en, FSM stays in BREAK until rxd rises.
REQ-038 Send 0x55 with fifo_full=1 -> overrun=1 and no wr_en; pulse overrun_clr -> overrun=0.
REQ-039 Assert rst_n=0 during bit 4 of 0xFF, release, then send 0x0F -> single write of 0x0F only.
